// File: rtl/alu_rr_sched_if.sv
// Request and response channels between the requesters, the response consumer
// and the round-robin ALU scheduler.
interface alu_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;

  // Requester / consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational 8-bit ALU among NREQ
// requesters. One operation in flight at a time: IDLE grants, EXEC lets the
// ALU settle on registered operands, RESP holds the result until consumed.
module alu_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_sched_if.slave     bus,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [7:0]        alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     alu_a_q, alu_a_d;
  logic [7:0]     alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;

  // Pick the first valid requester after the last grant, wrapping modulo NREQ.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_vld && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // State register: FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Datapath registers: ALU operands and captured response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: grant in IDLE, capture in EXEC, wait for consumer in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          alu_a_d  = bus.req_a[8*grant_idx +: 8];
          alu_b_d  = bus.req_b[8*grant_idx +: 8];
          alu_op_d = bus.req_op[3*grant_idx +: 3];
          rsp_id_d = grant_idx;
          ptr_d    = grant_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_err_d   = (alu_op_q == 3'd7);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: one-hot grant only while IDLE, busy otherwise.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_vld) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_opcode    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed vector table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_alu_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_opcode;
  logic       busy;

  alu_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 low-nibble multiply,
  // 5 add, 6 subtract (both wrap), 7 undefined -> 0.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = a[3:0] * b[3:0];
      3'd5: r = a + b;
      3'd6: r = a - b;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_opcode);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    bus.req_a[8*id +: 8]  = a;
    bus.req_b[8*id +: 8]  = b;
    bus.req_op[3*id +: 3] = op;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_alu_a"},     alu_a, 0);
    check({tag, "_alu_b"},     alu_b, 0);
    check({tag, "_alu_op"},    alu_opcode, 0);
    check({tag, "_rsp_data"},  bus.rsp_data, 0);
    check({tag, "_rsp_id"},    bus.rsp_id, 0);
    check({tag, "_rsp_err"},   bus.rsp_err, 0);
  endtask

  // Assert reset mid-cycle, verify outputs cleared at once, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  // One isolated request: grant same cycle, EXEC, RESP, back to IDLE.
  task automatic run_vec(input vec_t v, input int n);
    string t;
    t = $sformatf("vec%0d", n);
    @(negedge clk);
    bus.req_valid        = '0;
    bus.req_valid[v.id]  = 1'b1;
    set_req(v.id, v.a, v.b, v.op);
    bus.rsp_ready        = 1'b1;
    #1 check({t, "_grant"}, bus.req_ready, 32'(1 << v.id));
    check({t, "_idle_busy"}, busy, 0);
    @(negedge clk);
    bus.req_valid = '0;
    #1 check({t, "_exec_busy"}, busy, 1);
    check({t, "_exec_ready"}, bus.req_ready, 0);
    check({t, "_exec_rspv"}, bus.rsp_valid, 0);
    check({t, "_alu_a"}, alu_a, v.a);
    check({t, "_alu_b"}, alu_b, v.b);
    check({t, "_alu_op"}, alu_opcode, v.op);
    @(negedge clk);
    #1 check({t, "_rspv"}, bus.rsp_valid, 1);
    check({t, "_data"}, bus.rsp_data, v.exp_data);
    check({t, "_id"}, bus.rsp_id, v.id);
    check({t, "_err"}, bus.rsp_err, v.exp_err);
    @(negedge clk);
    #1 check({t, "_done_rspv"}, bus.rsp_valid, 0);
    check({t, "_done_busy"}, busy, 0);
    check({t, "_alu_hold"}, alu_a, v.a);
  endtask

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // Reset asserted mid-cycle clears every output immediately.
    #2 rst_n = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("por_busy", busy, 0);
    check("por_ready", bus.req_ready, 0);

    // Directed vectors.
    vecs[0] = '{0, 8'd200, 8'd100, 3'd5, 8'd44,   1'b0};
    vecs[1] = '{2, 8'hFF,  8'hFE,  3'd4, 8'hD2,   1'b0};
    vecs[2] = '{1, 8'd5,   8'd10,  3'd6, 8'd251,  1'b0};
    vecs[3] = '{3, 8'h12,  8'h34,  3'd7, 8'h00,   1'b1};
    vecs[4] = '{1, 8'hF0,  8'h3C,  3'd0, 8'h30,   1'b0};
    vecs[5] = '{2, 8'hF0,  8'h0F,  3'd1, 8'hFF,   1'b0};
    vecs[6] = '{3, 8'hAA,  8'hFF,  3'd2, 8'h55,   1'b0};
    vecs[7] = '{0, 8'h0F,  8'h99,  3'd3, 8'hF0,   1'b0};
    vecs[8] = '{0, 8'd255, 8'd1,   3'd5, 8'd0,    1'b0};
    vecs[9] = '{3, 8'd0,   8'd1,   3'd6, 8'd255,  1'b0};
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Arbitration: all requesters always valid -> grants 0,1,2,3,0 three cycles apart.
    begin
      int gid[$];
      int gcyc[$];
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i + 1), 8'd3, 3'd5);
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
        #1 check("arb_onehot", 32'($onehot0(bus.req_ready)), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_ready[i]) begin
            gid.push_back(i);
            gcyc.push_back(cyc);
          end
        end
        if (bus.rsp_valid)
          check("arb_data", bus.rsp_data, alu_fn(8'(16 * bus.rsp_id + 1), 8'd3, 3'd5));
        @(negedge clk);
      end
      check("arb_count", gid.size(), 5);
      for (int k = 0; k < 5 && k < gid.size(); k++) begin
        check($sformatf("arb_order%0d", k), gid[k], k % NREQ);
        if (k > 0) check($sformatf("arb_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
      end
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
    end

    // Backpressure: RESP holds for 5 cycles with other requesters waiting.
    do_reset();
    bus.req_valid    = '0;
    bus.req_valid[1] = 1'b1;
    set_req(1, 8'd9, 8'd7, 3'd5);
    bus.rsp_ready = 1'b0;
    #1 check("bp_grant", bus.req_ready, 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'b1101;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 check("bp_rspv", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, 16);
      check("bp_id", bus.rsp_id, 1);
      check("bp_ready", bus.req_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1 check("bp_rel_rspv", bus.rsp_valid, 1);
    @(negedge clk);
    #1 check("bp_idle_rspv", bus.rsp_valid, 0);
    check("bp_idle_busy", busy, 0);

    // Abort: grant requester 2, reset during EXEC, next grant must go to 0.
    @(negedge clk);
    bus.req_valid    = 4'b0100;
    set_req(2, 8'd50, 8'd60, 3'd5);
    #1 check("abort_grant", bus.req_ready, 32'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    #1 check("abort_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    #1 check("abort_rspv_in_rst", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("abort_rspv_after", bus.rsp_valid, 0);
    check("abort_busy_after", busy, 0);
    bus.req_valid = '1;
    #1 check("abort_next_grant", bus.req_ready, 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic against a transaction-level model.
    begin
      rsp_t            exp_q[$];
      rsp_t            e;
      logic [NREQ-1:0] vld;
      logic [NREQ-1:0] clr;
      logic [7:0]      ra [NREQ];
      logic [7:0]      rb [NREQ];
      logic [2:0]      rop[NREQ];
      int              last;
      int              g;
      int              outstanding;
      int              n_rsp;
      do_reset();
      vld   = '0;
      clr   = '0;
      last  = NREQ - 1;
      n_rsp = 0;
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = '0; rb[i] = '0; rop[i] = '0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (clr[i]) vld[i] = 1'b0;
          if (!vld[i]) begin
            if (!clr[i] && $urandom_range(3) == 0) begin
              vld[i] = 1'b1;
              ra[i]  = 8'($urandom);
              rb[i]  = 8'($urandom);
              rop[i] = 3'($urandom);
            end
          end else if ($urandom_range(15) == 0) begin
            vld[i] = 1'b0;
          end
          set_req(i, ra[i], rb[i], rop[i]);
        end
        clr           = '0;
        bus.req_valid = vld;
        bus.rsp_ready = ($urandom_range(2) != 0);
        #1;
        outstanding = exp_q.size();
        check("rnd_onehot", 32'($onehot0(bus.req_ready)), 1);
        check("rnd_busy", busy, outstanding != 0);
        if (outstanding == 0 && vld != 0) begin
          g = last;
          for (int k = 1; k <= NREQ; k++) begin
            if (vld[(last + k) % NREQ]) begin
              g = (last + k) % NREQ;
              break;
            end
          end
          check("rnd_grant", bus.req_ready, 32'(1 << g));
          e.id   = g;
          e.data = alu_fn(ra[g], rb[g], rop[g]);
          e.err  = (rop[g] == 3'd7);
          exp_q.push_back(e);
          last   = g;
          clr[g] = 1'b1;
        end else begin
          check("rnd_no_grant", bus.req_ready, 0);
        end
        if (outstanding == 0) check("rnd_rspv_idle", bus.rsp_valid, 0);
        if (bus.rsp_valid && bus.rsp_ready && outstanding != 0) begin
          e = exp_q.pop_front();
          n_rsp++;
          check("rnd_data", bus.rsp_data, e.data);
          check("rnd_id", bus.rsp_id, e.id);
          check("rnd_err", bus.rsp_err, e.err);
        end
        @(negedge clk);
      end
      check("rnd_activity", n_rsp > 100, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
